// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one 4-bit combinational ALU between two requesters.
// Optional build macro ALU_SCHED_LOCK_EN adds req_lock and a per-port lock owner.
module alu_sched (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic [3:0] req_op,
    input  logic [1:0] req_arit,
`ifdef ALU_SCHED_LOCK_EN
    input  logic [1:0] req_lock,
`endif
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_op,
    output logic       alu_arit,
    input  logic [3:0] alu_r,
    input  logic       alu_zero,
    input  logic       alu_carry,
    input  logic       alu_sign,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_r,
    output logic [2:0] rsp_flags
);

    localparam int unsigned DW  = 4;
    localparam int unsigned OPW = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
        logic [OPW-1:0] op;
        logic           arit;
    } alu_cmd_t;

    state_t   state_q, state_d;
    alu_cmd_t cmd_q, cmd_c;
    logic     ptr_q;
    logic     id_q;
    logic     win_c;
    logic [1:0] grant_c;
    logic     accept_c;
    logic     done_c;

`ifdef ALU_SCHED_LOCK_EN
    logic lock_vld_q;
    logic lock_id_q;
    logic op_lock_q;
`endif

    // Winner selection: lone requester wins, otherwise the favoured port; a lock overrides.
    always_comb begin
        grant_c = '0;
        case (req_valid)
            2'b01:   win_c = 1'b0;
            2'b10:   win_c = 1'b1;
            default: win_c = ptr_q;
        endcase
`ifdef ALU_SCHED_LOCK_EN
        if (lock_vld_q) win_c = lock_id_q;
`endif
        if (req_valid[win_c]) grant_c[win_c] = 1'b1;
    end

    always_comb begin
        if (win_c) cmd_c = '{a: req_a[7:4], b: req_b[7:4], op: req_op[3:2], arit: req_arit[1]};
        else       cmd_c = '{a: req_a[3:0], b: req_b[3:0], op: req_op[1:0], arit: req_arit[0]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state and handshake; ready is suppressed while reset is asserted.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                req_ready = grant_c & {2{reset_n}};
                if (|req_ready) state_d = EXEC;
            end
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign accept_c = (state_q == IDLE) && (|(req_valid & req_ready));
    assign done_c   = (state_q == RESP) && rsp_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q     <= '0;
            id_q      <= 1'b0;
            ptr_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_r     <= '0;
            rsp_flags <= '0;
        end else begin
            if (accept_c) begin
                cmd_q <= cmd_c;
                id_q  <= win_c;
            end
            if (state_q == EXEC) begin
                rsp_r     <= alu_r;
                rsp_flags <= {alu_zero, alu_carry, alu_sign};
                rsp_id    <= id_q;
                rsp_valid <= 1'b1;
            end
            if (done_c) begin
                rsp_valid <= 1'b0;
`ifdef ALU_SCHED_LOCK_EN
                if (!op_lock_q) ptr_q <= ~id_q;
`else
                ptr_q <= ~id_q;
`endif
            end
        end
    end

`ifdef ALU_SCHED_LOCK_EN
    // Lock owner is taken by a locked accept and released by that owner's next unlocked completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_vld_q <= 1'b0;
            lock_id_q  <= 1'b0;
            op_lock_q  <= 1'b0;
        end else begin
            if (accept_c) begin
                op_lock_q <= req_lock[win_c];
                if (req_lock[win_c]) begin
                    lock_vld_q <= 1'b1;
                    lock_id_q  <= win_c;
                end
            end
            if (done_c && !op_lock_q) lock_vld_q <= 1'b0;
        end
    end
`endif

    assign alu_a    = cmd_q.a;
    assign alu_b    = cmd_q.b;
    assign alu_op   = cmd_q.op;
    assign alu_arit = cmd_q.arit;

endmodule

// File: tb/tb_alu_sched.sv
// Directed self-checking bench for alu_sched with an adder ALU stub.
module tb_alu_sched;

    logic       clk;
    logic       reset_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [3:0] req_op;
    logic [1:0] req_arit;
`ifdef ALU_SCHED_LOCK_EN
    logic [1:0] req_lock;
`endif
    logic [3:0] alu_a, alu_b;
    logic [1:0] alu_op;
    logic       alu_arit;
    logic [3:0] alu_r;
    logic       alu_zero, alu_carry, alu_sign;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [3:0] rsp_r;
    logic [2:0] rsp_flags;

    int checks = 0;
    int errors = 0;

    alu_sched dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .req_arit  (req_arit),
`ifdef ALU_SCHED_LOCK_EN
        .req_lock  (req_lock),
`endif
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_arit  (alu_arit),
        .alu_r     (alu_r),
        .alu_zero  (alu_zero),
        .alu_carry (alu_carry),
        .alu_sign  (alu_sign),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_r     (rsp_r),
        .rsp_flags (rsp_flags)
    );

    // ALU stub: 4-bit add with carry-out, zero and sign flags
    logic [4:0] sum;
    assign sum       = 5'(alu_a) + 5'(alu_b);
    assign alu_r     = sum[3:0];
    assign alu_carry = sum[4];
    assign alu_zero  = (sum[3:0] == 4'd0);
    assign alu_sign  = sum[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete operation from IDLE with rsp_ready high.
    task automatic run_op(input string tag, input logic [1:0] exp_grant, input logic exp_id,
                          input logic [3:0] exp_r, input logic [2:0] exp_fl);
        #1;
        check({tag, "_grant"}, 8'(req_ready), 8'(exp_grant));
        tick();
        check({tag, "_exec_ready"}, 8'(req_ready), 8'h00);
        tick();
        check({tag, "_valid"}, 8'(rsp_valid), 8'h01);
        check({tag, "_id"}, 8'(rsp_id), 8'(exp_id));
        check({tag, "_r"}, 8'(rsp_r), 8'(exp_r));
        check({tag, "_flags"}, 8'(rsp_flags), 8'(exp_fl));
        tick();
        check({tag, "_done"}, 8'(rsp_valid), 8'h00);
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 2'b01;
        req_a     = 8'h03;
        req_b     = 8'h04;
        req_op    = 4'b0001;
        req_arit  = 2'b01;
        rsp_ready = 1'b1;
`ifdef ALU_SCHED_LOCK_EN
        req_lock  = 2'b00;
`endif
        tick();
        check("rst_ready", 8'(req_ready), 8'h00);
        check("rst_valid", 8'(rsp_valid), 8'h00);
        check("rst_r", 8'(rsp_r), 8'h00);
        check("rst_id", 8'(rsp_id), 8'h00);
        check("rst_alu_a", 8'(alu_a), 8'h00);
        #2 reset_n = 1'b1;
        #1;

        // Single request from port 0
        check("single_grant", 8'(req_ready), 8'h01);
        tick();
        req_valid = 2'b00;
        check("single_alu_a", 8'(alu_a), 8'h03);
        check("single_alu_b", 8'(alu_b), 8'h04);
        check("single_alu_op", 8'(alu_op), 8'h01);
        check("single_alu_arit", 8'(alu_arit), 8'h01);
        check("single_exec_valid", 8'(rsp_valid), 8'h00);
        tick();
        check("single_valid", 8'(rsp_valid), 8'h01);
        check("single_r", 8'(rsp_r), 8'h07);
        check("single_flags", 8'(rsp_flags), 8'h00);
        check("single_id", 8'(rsp_id), 8'h00);
        tick();
        check("single_done", 8'(rsp_valid), 8'h00);

        // Zero/wrap on port 1: 8+8 -> 0 with zero and carry
        req_valid = 2'b10;
        req_a     = 8'h80;
        req_b     = 8'h80;
        run_op("wrap", 2'b10, 1'b1, 4'h0, 3'b110);

        // Contention: both valid, grants alternate from port 0
        req_valid = 2'b11;
        req_a     = 8'h91;
        req_b     = 8'h91;
        run_op("cont0", 2'b01, 1'b0, 4'h2, 3'b000);
        run_op("cont1", 2'b10, 1'b1, 4'h2, 3'b010);
        run_op("cont2", 2'b01, 1'b0, 4'h2, 3'b000);
        run_op("cont3", 2'b10, 1'b1, 4'h2, 3'b010);

        // Backpressure: 5+6 on port 0, response held for 5 cycles
        req_valid = 2'b01;
        req_a     = 8'h05;
        req_b     = 8'h06;
        #1;
        check("bp_grant", 8'(req_ready), 8'h01);
        tick();
        req_valid = 2'b10;
        rsp_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 8'(rsp_valid), 8'h01);
            check("bp_r", 8'(rsp_r), 8'h0b);
            check("bp_flags", 8'(rsp_flags), 8'h01);
            check("bp_ready", 8'(req_ready), 8'h00);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_release", 8'(rsp_valid), 8'h00);
        check("bp_next_grant", 8'(req_ready), 8'h02);
        req_valid = 2'b00;
        tick();

        // Reset during EXEC drops the operation and restores port-0 priority
        req_valid = 2'b10;
        req_a     = 8'h20;
        req_b     = 8'h30;
        #1;
        check("rx_grant", 8'(req_ready), 8'h02);
        tick();
        req_valid = 2'b00;
        reset_n   = 1'b0;
        #1;
        check("rx_valid_low", 8'(rsp_valid), 8'h00);
        check("rx_ready_low", 8'(req_ready), 8'h00);
        #1 reset_n = 1'b1;
        tick();
        check("rx_no_rsp", 8'(rsp_valid), 8'h00);
        check("rx_r", 8'(rsp_r), 8'h00);
        check("rx_alu_a", 8'(alu_a), 8'h00);
        req_valid = 2'b11;
        req_a     = 8'h91;
        req_b     = 8'h91;
        run_op("rx_cont", 2'b01, 1'b0, 4'h2, 3'b000);

`ifdef ALU_SCHED_LOCK_EN
        // Port 1 holds the lock for three operations despite port 0 waiting
        req_lock = 2'b10;
        run_op("lock0", 2'b10, 1'b1, 4'h2, 3'b010);
        run_op("lock1", 2'b10, 1'b1, 4'h2, 3'b010);
        run_op("lock2", 2'b10, 1'b1, 4'h2, 3'b010);
        req_lock = 2'b00;
        run_op("unlock", 2'b10, 1'b1, 4'h2, 3'b010);
        #1;
        check("lock_release_grant", 8'(req_ready), 8'h01);
`endif

        req_valid = 2'b00;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sched.md
# alu_sched

Two-port round-robin scheduler that shares the single 4-bit ALU between two requesters, for example the instruction sequencer and a second micro-controller. It accepts one operation at a time through a valid/ready handshake and drives the operands and opcode into the ALU for exactly one cycle. It registers the result and the zero/carry/sign flags, and returns them to the winning requester with its port ID. It sits between the requesters and the combinational ALU. The ALU's ports connect directly to the `alu_*` signals.

## Interface
Parameters:
- none; data width is fixed at 4 bits and the requester count at 2.

Ports:
- `clk`  in  1  single system clock; everything is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  bit i = requester i has an operation pending.
- `req_ready`  out  2  bit i = requester i's operation is accepted this cycle; at most one bit is high.
- `req_a`  in  8  operand A, {port1[7:4], port0[3:0]}.
- `req_b`  in  8  operand B, same packing as `req_a`.
- `req_op`  in  4  ALUOp, {port1[3:2], port0[1:0]}.
- `req_arit`  in  2  arithmetic/logic select, one bit per port.
- `req_lock`  in  2  lock request, one bit per port; present only with `ALU_SCHED_LOCK_EN`.
- `alu_a`, `alu_b`  out  4  ALU operands.
- `alu_op`  out  2  ALU ALUOp.
- `alu_arit`  out  1  ALU arit.
- `alu_r`  in  4  ALU result.
- `alu_zero`, `alu_carry`, `alu_sign`  in  1  ALU flags.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  requester consumes the response.
- `rsp_id`  out  1  port that issued the operation.
- `rsp_r`  out  4  registered result.
- `rsp_flags`  out  3  {zero, carry, sign}.

## Operation
State machine, encoded in 2 bits: IDLE, EXEC, RESP.

- **IDLE:**
  - The grant is combinational. `ptr` names the favoured port.
  - If only one port is valid, it wins.
  - If both are valid, port `ptr` wins.
  - `req_ready` is asserted only for the winner.
  - At the clock edge where `req_valid & req_ready` is true:
    - latch a, b, op and arit into the operand registers;
    - latch the port into `id_q`;
    - go to EXEC.
- **EXEC:**
  - `alu_*` outputs are driven from the operand registers; they hold their last value in every other state.
  - At the edge: capture `alu_r` and the flags into the `rsp_*` registers, set `rsp_valid`, go to RESP.
- **RESP:**
  - `rsp_valid` = 1.
  - At the edge where `rsp_ready` = 1: clear `rsp_valid`, set `ptr <= ~id_q`, go to IDLE.
  - `rsp_r`, `rsp_flags` and `rsp_id` are stable for as long as `rsp_valid` is high.
- `req_ready` = 0 in EXEC and in RESP. A pending request simply waits.
- The scheduler does not interpret the opcode. Every ALUOp/arit combination is passed through unchanged.
- Requester contract:
  - `req_*` data must stay stable while `req_valid` is high and the request is not yet accepted.
  - Dropping `req_valid` before acceptance is legal; the request is withdrawn.

## Timing
Values after `reset_n` goes low:
- state = IDLE;
- `ptr` = 0 (port 0 favoured);
- operand registers, `rsp_r`, `rsp_flags`, `rsp_id` = 0;
- `rsp_valid` = 0;
- `req_ready` = 0 while `reset_n` is low;
- lock owner cleared.

Latency and throughput:
- If the request is accepted at edge k, `rsp_valid` rises after edge k+1.
- Minimum of 3 cycles per operation: accept, exec, response consumed at the first RESP edge.

Boundary conditions:
- **Reset mid-EXEC or mid-RESP:** the operation is dropped. No response is produced and the requester must re-issue.
- **Both ports valid on every cycle:** grants strictly alternate 0, 1, 0, 1. No port starves.
- **`rsp_ready` held high:** RESP lasts exactly one cycle.
- **`rsp_ready` held low:** the block stalls in RESP indefinitely and no new grant is issued.

## Configuration
- **With `ALU_SCHED_LOCK_EN` defined:**
  - `req_lock` exists.
  - An operation accepted with `req_lock[i]` = 1 sets lock owner = i.
  - While the lock owner is valid, only port i can be granted. `ptr` is not rotated on completion.
  - The lock clears when port i completes an operation that was accepted with `req_lock[i]` = 0.
  - Reset clears the lock.
- **Without it:** the port is absent, no lock register exists, and arbitration is pure round-robin.

## Test plan
The bench uses an ALU stub whose result is `alu_r = alu_a + alu_b`, whose zero flag is `(alu_r == 0)`, and whose carry flag is the add carry-out.

- **Single request:** port 0 requests a=3, b=4, op=2'b01, arit=1; `rsp_ready`=1.
  - `req_ready` = 2'b01 in the same cycle.
  - `alu_a`=3, `alu_b`=4, `alu_op`=01, `alu_arit`=1 in EXEC.
  - `rsp_valid` one cycle later, with `rsp_r`=7, `rsp_flags`=3'b000, `rsp_id`=0.
- **Contention:** both ports valid continuously (port 0: a=1, b=1; port 1: a=9, b=9).
  - Responses alternate: id 0 with r=2, id 1 with r=2 and carry=1, id 0, id 1.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles.
  - `rsp_valid` and `rsp_r` stay constant.
  - `req_ready` = 0 throughout.
  - A single `rsp_ready` pulse returns the block to IDLE.
- **Zero/wrap:** a=8, b=8.
  - `rsp_r`=0 and `rsp_flags`=3'b110.
- **Reset in EXEC:** pulse `reset_n` low.
  - `rsp_valid` stays 0.
  - `ptr` = 0, so port 0 wins the next contention.
- **Lock (`ALU_SCHED_LOCK_EN` defined):** port 1 issues 3 locked operations with port 0 valid throughout.
  - All three responses have id 1.
  - Port 1's next operation is unlocked; port 0 is granted after it completes.
